// File: rtl/mig_app_pkg.sv
// mig_app_pkg: MIG UI widths, command codes and responder FSM states shared with RAM_CONTROLLER
package mig_app_pkg;
  localparam int MIG_UI_DATA_W = 128;
  localparam int MIG_UI_ADDR_W = 28;
  localparam int MIG_UI_MASK_W = MIG_UI_DATA_W / 8;
  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ = 3'b001;
  typedef logic [1:0] mig_state_t;
  localparam mig_state_t ST_IDLE = 2'd0;
  localparam mig_state_t ST_WAIT_DATA = 2'd1;
  localparam mig_state_t ST_COMMIT = 2'd2;
endpackage

// File: rtl/mig_app_wdf_fifo.sv
// mig_app_wdf_fifo: 2-entry {data, mask} write-data FIFO with full/empty flags
module mig_app_wdf_fifo import mig_app_pkg::*; #(
  parameter int W = MIG_UI_DATA_W + MIG_UI_MASK_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem_q [2];
  logic wp_q, rp_q;
  logic [1:0] cnt_q;
  assign full = cnt_q == 2'd2;
  assign empty = cnt_q == 2'd0;
  assign rdata = mem_q[rp_q];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) mem_q[wp_q] <= wdata;
      wp_q <= wp_q ^ push;
      rp_q <= rp_q ^ pop;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/mig_app_responder.sv
// mig_app_responder: MIG 7-series UI memory-side stand-in; refresh stalls under `MIG_APP_RESPONDER_REFRESH_EN
module mig_app_responder import mig_app_pkg::*; #(
  parameter int CHUNK_PART = MIG_UI_DATA_W,
  parameter int ADDRESS_SIZE = MIG_UI_ADDR_W,
  parameter int LINES_LOG2 = 10,
  parameter int READ_LATENCY = 4,
  parameter int INIT_CYCLES = 16,
  parameter int REFRESH_INTERVAL = 256,
  parameter int REFRESH_BUSY = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRESS_SIZE-1:0] mig_app_addr,
  input  logic [2:0]              mig_app_cmd,
  input  logic                    mig_app_en,
  output logic                    mig_app_rdy,
  input  logic [CHUNK_PART-1:0]   mig_app_wdf_data,
  input  logic [CHUNK_PART/8-1:0] mig_app_wdf_mask,
  input  logic                    mig_app_wdf_wren,
  input  logic                    mig_app_wdf_end,
  output logic                    mig_app_wdf_rdy,
  output logic [CHUNK_PART-1:0]   mig_app_rd_data,
  output logic                    mig_app_rd_data_valid,
  output logic                    mig_app_rd_data_end,
  output logic                    mig_app_sr_active,
  output logic                    mig_app_zq_ack,
  output logic                    mig_app_ref_ack,
  output logic                    mig_init_calib_complete,
  output logic [2:0]              protocol_error
);
  localparam int MW = CHUNK_PART / 8;
  logic [CHUNK_PART-1:0] mem [1 << LINES_LOG2];
  mig_state_t state_q, state_d;
  logic [LINES_LOG2-1:0] line_q, line_d, line;
  logic [31:0] init_q;
  logic [2:0] perr_q, perr_d;
  logic [READ_LATENCY-1:0] rv_q;
  logic [CHUNK_PART-1:0] rd_q [READ_LATENCY];
  logic [CHUNK_PART+MW-1:0] fifo_out;
  logic [CHUNK_PART-1:0] head_data, old, merged;
  logic [MW-1:0] head_mask;
  logic calib, full, empty, push, pop, acc, wr_acc, rd_acc, refresh_busy, unused_ok;
  assign calib = init_q == 32'(INIT_CYCLES);
  assign mig_init_calib_complete = calib;
  assign mig_app_rdy = calib && state_q == ST_IDLE && !refresh_busy;
  assign mig_app_wdf_rdy = calib && !full;
  assign push = mig_app_wdf_wren && mig_app_wdf_rdy;
  assign acc = mig_app_en && mig_app_rdy;
  assign wr_acc = acc && mig_app_cmd == MIG_CMD_WRITE;
  assign rd_acc = acc && mig_app_cmd == MIG_CMD_READ;
  assign pop = state_q == ST_COMMIT;
  assign line = mig_app_addr[LINES_LOG2+2:3];
  assign old = mem[line_q];
  assign head_data = fifo_out[CHUNK_PART+MW-1:MW];
  assign head_mask = fifo_out[MW-1:0];
  assign state_d = (state_q == ST_COMMIT) ? ST_IDLE :
                   (state_q == ST_WAIT_DATA || wr_acc) ? ((push || !empty) ? ST_COMMIT : ST_WAIT_DATA) :
                   ST_IDLE;
  assign line_d = wr_acc ? line : line_q;
  assign perr_d = perr_q | {mig_app_wdf_wren && !mig_app_wdf_rdy,
                            mig_app_wdf_wren && !mig_app_wdf_end,
                            acc && mig_app_cmd != MIG_CMD_WRITE && mig_app_cmd != MIG_CMD_READ};
  assign mig_app_rd_data_valid = rv_q[READ_LATENCY-1];
  assign mig_app_rd_data_end = rv_q[READ_LATENCY-1];
  assign mig_app_rd_data = rd_q[READ_LATENCY-1];
  assign mig_app_sr_active = 1'b0;
  assign mig_app_zq_ack = 1'b0;
  assign protocol_error = perr_q;
  assign unused_ok = ^{mig_app_addr[ADDRESS_SIZE-1:LINES_LOG2+3], mig_app_addr[2:0],
                       REFRESH_INTERVAL[0], REFRESH_BUSY[0]};
  mig_app_wdf_fifo #(.W(CHUNK_PART + MW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata({mig_app_wdf_data, mig_app_wdf_mask}),
    .rdata(fifo_out),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    merged = old;
    for (int b = 0; b < MW; b++) merged[b*8 +: 8] = head_mask[b] ? old[b*8 +: 8] : head_data[b*8 +: 8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      line_q <= '0;
      init_q <= '0;
      perr_q <= '0;
      rv_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) rd_q[i] <= '0;
    end else begin
      state_q <= state_d;
      line_q <= line_d;
      init_q <= calib ? init_q : init_q + 32'd1;
      perr_q <= perr_d;
      rv_q <= {rv_q[READ_LATENCY-2:0], rd_acc};
      rd_q[0] <= rd_acc ? mem[line] : '0;
      for (int i = 1; i < READ_LATENCY; i++) rd_q[i] <= rd_q[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (pop && !reset) mem[line_q] <= merged;
  end
`ifdef MIG_APP_RESPONDER_REFRESH_EN
  logic [31:0] ref_cnt_q, busy_cnt_q;
  logic ref_ack_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt_q <= '0;
      busy_cnt_q <= '0;
      ref_ack_q <= 1'b0;
    end else begin
      ref_cnt_q <= (ref_cnt_q == 32'(REFRESH_INTERVAL - 1)) ? '0 : ref_cnt_q + 32'd1;
      busy_cnt_q <= (ref_cnt_q == 32'(REFRESH_INTERVAL - 1)) ? 32'(REFRESH_BUSY) :
                    (busy_cnt_q != '0) ? busy_cnt_q - 32'd1 : '0;
      ref_ack_q <= busy_cnt_q == 32'd1;
    end
  end
  assign refresh_busy = busy_cnt_q != '0;
  assign mig_app_ref_ack = ref_ack_q;
`else
  assign refresh_busy = 1'b0;
  assign mig_app_ref_ack = 1'b0;
`endif
endmodule
